// File: rtl/sequence_blinker.sv
// Simon Says playback engine: reads sequence entries 0..level-1 from memory and
// shows each colour on a one-hot LED bus for ON_CYCLES, then a dark gap of OFF_CYCLES.
module sequence_blinker #(
  parameter int ON_CYCLES  = 12_500_000,
  parameter int OFF_CYCLES = 6_250_000,
  parameter int CW         = $clog2((ON_CYCLES > OFF_CYCLES ? ON_CYCLES : OFF_CYCLES) + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       on_blinker,
  input  logic [3:0] level,
  output logic [3:0] mem_addr,
  output logic       mem_rd,
  input  logic [1:0] mem_data,
  output logic [3:0] leds,
  output logic       blinker_done
);

  // state   | meaning
  // IDLE    | waiting for on_blinker
  // FETCH   | read strobe for entry idx is on the bus
  // LATCH   | memory data valid, captured into colour
  // ON      | LED lit for ON_CYCLES
  // OFF     | dark gap for OFF_CYCLES
  // DONE    | playback complete, held until on_blinker drops
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_ON, S_OFF, S_DONE
  } state_t;

  localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES);
  localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_CYCLES);
  localparam logic [CW-1:0] T_LAST   = CW'(1);

  state_t        state;
  logic [3:0]    idx;
  logic [3:0]    lvl;
  logic [CW-1:0] timer;
  logic [1:0]    colour;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      idx          <= 4'd0;
      lvl          <= 4'd0;
      timer        <= '0;
      colour       <= 2'd0;
      mem_addr     <= 4'd0;
      mem_rd       <= 1'b0;
      leds         <= 4'd0;
      blinker_done <= 1'b0;
    end else begin
      mem_rd <= 1'b0;
      case (state)
        S_IDLE: begin
          if (on_blinker) begin
            if (level != 4'd0) begin
              lvl      <= level;
              idx      <= 4'd0;
              mem_addr <= 4'd0;
              mem_rd   <= 1'b1;
              state    <= S_FETCH;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_FETCH: begin
          state <= on_blinker ? S_LATCH : S_IDLE;
        end
        S_LATCH: begin
          if (!on_blinker) begin
            state <= S_IDLE;
          end else begin
            colour <= mem_data;
            leds   <= 4'b0001 << mem_data;
            timer  <= ON_LOAD;
            state  <= S_ON;
          end
        end
        S_ON: begin
          if (!on_blinker) begin
            leds  <= 4'd0;
            state <= S_IDLE;
          end else if (timer == T_LAST) begin
            leds  <= 4'd0;
            timer <= OFF_LOAD;
            state <= S_OFF;
          end else begin
            leds  <= 4'b0001 << colour;
            timer <= timer - T_LAST;
          end
        end
        S_OFF: begin
          if (!on_blinker) begin
            state <= S_IDLE;
          end else if (timer == T_LAST) begin
            // lvl <= 15 keeps idx from ever wrapping
            if (idx == lvl - 4'd1) begin
              blinker_done <= 1'b1;
              state        <= S_DONE;
            end else begin
              idx      <= idx + 4'd1;
              mem_addr <= idx + 4'd1;
              mem_rd   <= 1'b1;
              state    <= S_FETCH;
            end
          end else begin
            timer <= timer - T_LAST;
          end
        end
        S_DONE: begin
          leds <= 4'd0;
          if (!on_blinker) begin
            blinker_done <= 1'b0;
            state        <= S_IDLE;
          end else begin
            blinker_done <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sequence_blinker.md
Name: sequence_blinker

Overview:
- Playback engine for the Simon Says game; it is the reader side of the sequence memory the game controller writes.
- While the controller holds on_blinker high, the block reads memory entries 0..level-1 and shows each colour on a one-hot LED bus for a fixed on-time, followed by a dark gap.
- After the last entry it asserts blinker_done, which releases the controller into the player-input phase.

Parameters:
- ON_CYCLES, 12_500_000: clock cycles an LED stays lit per step (0.25 s at 50 MHz); must be >= 1.
- OFF_CYCLES, 6_250_000: dark cycles after each lit step; must be >= 1.
- CW, $clog2(max(ON_CYCLES,OFF_CYCLES)+1): width of the internal timer.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- on_blinker  in  1  playback enable from the game controller; held high for the whole blink phase
- level  in  4  number of entries to play (0..15); latched on start
- mem_addr  out  4  sequence memory read address
- mem_rd  out  1  memory read strobe; memory returns data the following cycle
- mem_data  in  2  colour index read from memory (valid one cycle after mem_rd)
- leds  out  4  one-hot colour display; 4'b0000 when dark
- blinker_done  out  1  playback complete; high while in DONE

Behaviour:
- One clock (clk). Reset is synchronous and active-high; all state and outputs are registered.
- Reset state: state=IDLE, idx=0, timer=0, colour=0, mem_addr=0, mem_rd=0, leds=0, blinker_done=0.
- States: IDLE, FETCH, LATCH, ON, OFF, DONE. Step period P = ON_CYCLES + OFF_CYCLES + 2.
- IDLE:
  - on_blinker=1 and level!=0: latch lvl=level, set idx=0, go to FETCH.
  - on_blinker=1 and level==0: go directly to DONE (no memory reads, LEDs stay dark).
  - Otherwise stay in IDLE.
- FETCH (1 cycle): mem_addr=idx, mem_rd=1; go to LATCH.
- LATCH (1 cycle): capture colour <= mem_data, load timer; go to ON.
- ON (exactly ON_CYCLES cycles): leds = 1 << colour; then go to OFF.
- OFF (exactly OFF_CYCLES cycles): leds=0.
  - At expiry, if idx == lvl-1, go to DONE.
  - Otherwise idx <= idx+1 and go to FETCH.
- DONE: blinker_done=1, leds=0. Stay while on_blinker=1; return to IDLE on the first cycle on_blinker=0.
  - The block does not re-arm until on_blinker has been seen low. This absorbs the controller's one-cycle registered-output lag.
- mem_rd is high only in FETCH; mem_addr holds its last value at all other times.
- Latency: if on_blinker is sampled high at edge 0 with level=L>=1, blinker_done rises at edge L*P. The first LED lights at edge 2.
- Abort: on_blinker=0 in FETCH, LATCH, ON or OFF forces IDLE next cycle with leds=0 and blinker_done=0; no partial done.
- A change of level during playback is ignored; the value latched at start is used.
- reset=1 in any state overrides everything and returns to the reset state next cycle.
- Memory-rule check: mem_data is only captured in LATCH, so garbage on mem_data at any other time has no effect.
- Arithmetic: idx is 4 bits with no wrap, since lvl<=15 bounds it. The timer counts down to 1 and is reloaded on each state entry.

Test Plan:
- Reset: assert reset for 2 cycles mid-ON -> next cycle leds=0, blinker_done=0, mem_rd=0, state IDLE; with on_blinker=0 nothing changes.
- Basic playback (ON=4, OFF=2, P=8), memory {2,0,3}, level=3, on_blinker held high:
  - mem_rd high with addr 0, 1, 2 at edges 0, 8, 16.
  - leds 4'b0100 for cycles 2-5, 4'b0001 for cycles 10-13, 4'b1000 for cycles 18-21.
  - blinker_done rises at edge 24.
- Done handshake: keep on_blinker high 3 cycles past done -> blinker_done stays 1. Drop on_blinker -> IDLE next cycle. Raise on_blinker with level=1 -> new playback starts (mem_addr=0).
- level=0 with on_blinker=1 -> blinker_done at edge 1, no mem_rd, leds never nonzero.
- Abort: drop on_blinker during step 2 ON -> leds=0 next cycle, blinker_done never asserts. Restart with level=2 -> plays from addr 0.
- level=15 with memory all 1 -> 15 reads at addr 0..14, leds=4'b0010 in each ON window, blinker_done at edge 120.
